// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//
// Shared constants for the UART receive path.
//   BYTE_W             : width of one UART character on the parallel side.
//   DEFAULT_DEPTH_LOG2 : default log2 depth of the receive buffer.
//
// depth_of() turns a log2 depth into an entry count. It is used wherever a
// full-scale count value has to be formed at the count register's width.
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEFAULT_DEPTH_LOG2 = 4;

    function automatic int depth_of(input int depth_log2);
        return 1 << depth_log2;
    endfunction

endpackage

// File: rtl/uart_byte_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_byte_fifo_mem
//
// Simple dual-port register array: one synchronous write port and one
// asynchronous (combinational) read port. It holds no pointer or flag state,
// so it can be swapped for an SRAM macro without touching the control logic.
// The contents are never reset.
//
// Parameters
//   ADDR_W : address width; the array holds 2**ADDR_W words.
//   DATA_W : word width.
//
// Ports
//   clk   in   clock
//   we    in   write enable, sampled on the rising edge
//   waddr in   write address
//   wdata in   write data
//   raddr in   read address
//   rdata out  word stored at raddr (combinational)
// -----------------------------------------------------------------------------
module uart_byte_fifo_mem #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int WORDS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// -----------------------------------------------------------------------------
// uart_rx_buffer
//
// Receive-side byte FIFO between the UART receiver and the bus interface.
// Each byte strobed in with rxDataAvailable is stored in a circular buffer.
// The oldest byte is presented on readData and popped with readAck. Fill
// level, a sticky overflow flag and a threshold interrupt are reported.
//
// Parameters
//   DEPTH_LOG2 : buffer holds 2**DEPTH_LOG2 bytes (legal range 1..8).
//
// Ports
//   clk             in   clock
//   rst             in   synchronous reset, active-high
//   rxData          in   received byte, sampled when rxDataAvailable is high
//   rxDataAvailable in   single-cycle strobe marking a new byte
//   readData        out  oldest stored byte (valid while dataReady is high)
//   dataReady       out  buffer not empty
//   readAck         in   pop the head entry this cycle
//   count           out  number of stored bytes, 0..2**DEPTH_LOG2
//   full            out  count equals the depth
//   overflow        out  sticky, set when a byte is dropped
//   clearOverflow   in   clears overflow (a same-cycle drop wins)
//   flush           in   empties the buffer, overrides push/pop
//   irqThreshold    in   interrupt level, 0 disables the interrupt
//   irq             out  irqThreshold != 0 && count >= irqThreshold
// -----------------------------------------------------------------------------
module uart_rx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BYTE_W-1:0]     rxData,
    input  logic                  rxDataAvailable,
    output logic [BYTE_W-1:0]     readData,
    output logic                  dataReady,
    input  logic                  readAck,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    input  logic                  clearOverflow,
    input  logic                  flush,
    input  logic [DEPTH_LOG2:0]   irqThreshold,
    output logic                  irq
);

    localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2 + 1)'(depth_of(DEPTH_LOG2));

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;

    logic push;
    logic pop;
    logic drop;
    logic mem_we;

    // Flag decodes straight from the registered count.
    assign full      = (count_q == DEPTH);
    assign dataReady = (count_q != '0);
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign irq       = (irqThreshold != '0) && (count_q >= irqThreshold);

    // A pop in the same cycle frees a slot, so a full buffer still accepts
    // the incoming byte when readAck is high. Full implies non-empty, so in
    // that case pop is guaranteed to fire alongside push.
    assign push = rxDataAvailable && (!full || readAck);
    assign pop  = readAck && dataReady;
    assign drop = rxDataAvailable && full && !readAck;

    // The array is never written on a flush or reset cycle; the byte would be
    // discarded by the pointer clear anyway.
    assign mem_we = push && !flush && !rst;

    uart_byte_fifo_mem #(
        .ADDR_W (DEPTH_LOG2),
        .DATA_W (BYTE_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (rxData),
        .raddr (rd_ptr),
        .rdata (readData)
    );

    // Pointers wrap naturally at the depth since they are exactly
    // DEPTH_LOG2 bits wide; count carries the extra bit that separates
    // full from empty.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            // Set has priority over clear so a drop is never hidden.
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clearOverflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_buffer.sv
module tb_uart_rx_buffer;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_av;
    logic       ack;
    logic       clr;
    logic       fl;
    logic [4:0] thr;

    // depth-4 instance (DEPTH_LOG2 = 2)
    logic [7:0] rd2;
    logic       rdy2, full2, ovf2, irq2;
    logic [2:0] cnt2;
    // depth-16 instance (DEPTH_LOG2 = 4)
    logic [7:0] rd4;
    logic       rdy4, full4, ovf4, irq4;
    logic [4:0] cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    uart_rx_buffer #(.DEPTH_LOG2(2)) dut2 (
        .clk(clk), .rst(rst), .rxData(rx_data), .rxDataAvailable(rx_av),
        .readData(rd2), .dataReady(rdy2), .readAck(ack), .count(cnt2),
        .full(full2), .overflow(ovf2), .clearOverflow(clr), .flush(fl),
        .irqThreshold(thr[2:0]), .irq(irq2)
    );

    uart_rx_buffer #(.DEPTH_LOG2(4)) dut4 (
        .clk(clk), .rst(rst), .rxData(rx_data), .rxDataAvailable(rx_av),
        .readData(rd4), .dataReady(rdy4), .readAck(ack), .count(cnt4),
        .full(full4), .overflow(ovf4), .clearOverflow(clr), .flush(fl),
        .irqThreshold(thr), .irq(irq4)
    );

    typedef struct {
        logic [7:0] d;
        logic       av;
        logic       ack;
        logic       clr;
        logic [4:0] thr;
        logic [2:0] cnt;
        logic       rdy;
        logic [7:0] rd;
        logic       full;
        logic       ovf;
        logic       irq;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] d, input logic av, input logic a,
                                input logic c, input logic [4:0] t,
                                input logic [2:0] n, input logic r, input logic [7:0] q,
                                input logic f, input logic o, input logic i);
        vec_t v;
        v.d = d; v.av = av; v.ack = a; v.clr = c; v.thr = t;
        v.cnt = n; v.rdy = r; v.rd = q; v.full = f; v.ovf = o; v.irq = i;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, sample 1 time unit after rising.
    task automatic step(input logic [7:0] d, input logic av, input logic a,
                        input logic c, input logic f);
        @(negedge clk);
        rx_data = d; rx_av = av; ack = a; clr = c; fl = f;
        @(posedge clk);
        #1;
        rx_av = 1'b0; ack = 1'b0; clr = 1'b0; fl = 1'b0;
    endtask

    initial begin
        rst = 1'b1; rx_data = 8'h00; rx_av = 1'b0; ack = 1'b0;
        clr = 1'b0; fl = 1'b0; thr = 5'd1;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        check("reset_count2", cnt2, 0);
        check("reset_ready2", rdy2, 0);
        check("reset_full2",  full2, 0);
        check("reset_ovf2",   ovf2, 0);
        check("reset_irq2",   irq2, 0);
        check("reset_count4", cnt4, 0);
        check("reset_irq4",   irq4, 0);
        @(negedge clk);
        rst = 1'b0; thr = 5'd0;

        // ---------------- table (checked on the depth-4 instance) ----------------
        //               d     av ack clr thr   cnt rdy rd    full ovf irq
        // basic push / pop
        tbl.push_back(mk(8'h41, 1, 0, 0, 0,    1, 1, 8'h41, 0, 0, 0));
        tbl.push_back(mk(8'h42, 1, 0, 0, 0,    2, 1, 8'h41, 0, 0, 0));
        tbl.push_back(mk(8'h43, 1, 0, 0, 0,    3, 1, 8'h41, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    2, 1, 8'h42, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    1, 1, 8'h43, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    0, 0, 8'h00, 0, 0, 0));
        // overflow: 5 bytes into 4 slots, 0x14 lost
        tbl.push_back(mk(8'h10, 1, 0, 0, 0,    1, 1, 8'h10, 0, 0, 0));
        tbl.push_back(mk(8'h11, 1, 0, 0, 0,    2, 1, 8'h10, 0, 0, 0));
        tbl.push_back(mk(8'h12, 1, 0, 0, 0,    3, 1, 8'h10, 0, 0, 0));
        tbl.push_back(mk(8'h13, 1, 0, 0, 0,    4, 1, 8'h10, 1, 0, 0));
        tbl.push_back(mk(8'h14, 1, 0, 0, 0,    4, 1, 8'h10, 1, 1, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    3, 1, 8'h11, 0, 1, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    2, 1, 8'h12, 0, 1, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    1, 1, 8'h13, 0, 1, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    0, 0, 8'h00, 0, 1, 0));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0,    0, 0, 8'h00, 0, 0, 0));
        // full with simultaneous push and pop
        tbl.push_back(mk(8'h20, 1, 0, 0, 0,    1, 1, 8'h20, 0, 0, 0));
        tbl.push_back(mk(8'h21, 1, 0, 0, 0,    2, 1, 8'h20, 0, 0, 0));
        tbl.push_back(mk(8'h22, 1, 0, 0, 0,    3, 1, 8'h20, 0, 0, 0));
        tbl.push_back(mk(8'h23, 1, 0, 0, 0,    4, 1, 8'h20, 1, 0, 0));
        tbl.push_back(mk(8'h55, 1, 1, 0, 0,    4, 1, 8'h21, 1, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    3, 1, 8'h22, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    2, 1, 8'h23, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    1, 1, 8'h55, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    0, 0, 8'h00, 0, 0, 0));
        // readAck while empty is ignored
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    0, 0, 8'h00, 0, 0, 0));
        tbl.push_back(mk(8'h7E, 1, 0, 0, 0,    1, 1, 8'h7E, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    0, 0, 8'h00, 0, 0, 0));
        // threshold interrupt
        tbl.push_back(mk(8'hA0, 1, 0, 0, 3,    1, 1, 8'hA0, 0, 0, 0));
        tbl.push_back(mk(8'hA1, 1, 0, 0, 3,    2, 1, 8'hA0, 0, 0, 0));
        tbl.push_back(mk(8'hA2, 1, 0, 0, 3,    3, 1, 8'hA0, 0, 0, 1));
        tbl.push_back(mk(8'h00, 0, 1, 0, 3,    2, 1, 8'hA1, 0, 0, 0));
        tbl.push_back(mk(8'hA3, 1, 0, 0, 0,    3, 1, 8'hA1, 0, 0, 0));
        tbl.push_back(mk(8'hA4, 1, 0, 0, 0,    4, 1, 8'hA1, 1, 0, 0));
        // drop and clearOverflow together: set wins; threshold equal to depth
        tbl.push_back(mk(8'hB0, 1, 0, 1, 4,    4, 1, 8'hA1, 1, 1, 1));
        tbl.push_back(mk(8'h00, 0, 0, 1, 0,    4, 1, 8'hA1, 1, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    3, 1, 8'hA2, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    2, 1, 8'hA3, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    1, 1, 8'hA4, 0, 0, 0));
        tbl.push_back(mk(8'h00, 0, 1, 0, 0,    0, 0, 8'h00, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rx_data = tbl[i].d; rx_av = tbl[i].av; ack = tbl[i].ack;
            clr = tbl[i].clr; thr = tbl[i].thr; fl = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), cnt2,  tbl[i].cnt);
            check($sformatf("v%0d_ready", i), rdy2,  tbl[i].rdy);
            check($sformatf("v%0d_full", i),  full2, tbl[i].full);
            check($sformatf("v%0d_ovf", i),   ovf2,  tbl[i].ovf);
            check($sformatf("v%0d_irq", i),   irq2,  tbl[i].irq);
            if (tbl[i].rdy)
                check($sformatf("v%0d_data", i), rd2, tbl[i].rd);
        end
        @(negedge clk);
        rx_av = 1'b0; ack = 1'b0; clr = 1'b0; thr = 5'd0;

        // ---------------- flush with stored data and a simultaneous push ----------------
        for (int k = 0; k < 5; k++) step(8'hC0 + 8'(k), 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("preflush_count", cnt2, 3);
        check("preflush_ovf",   ovf2, 1);
        step(8'h99, 1'b1, 1'b0, 1'b0, 1'b1);
        check("flush_count", cnt2, 0);
        check("flush_ready", rdy2, 0);
        check("flush_ovf",   ovf2, 0);
        check("flush_full",  full2, 0);
        step(8'h66, 1'b1, 1'b0, 1'b0, 1'b0);
        check("postflush_count", cnt2, 1);
        check("postflush_data",  rd2, 8'h66);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("postflush_drain", cnt2, 0);

        // ---------------- reset mid-transfer, strobe lost ----------------
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
        step(8'h02, 1'b1, 1'b0, 1'b0, 1'b0);
        check("premrst_count4", cnt4, 2);
        @(negedge clk);
        rst = 1'b1; rx_data = 8'h03; rx_av = 1'b1;
        @(posedge clk);
        #1;
        rx_av = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_count2", cnt2, 0);
        check("midrst_count4", cnt4, 0);
        check("midrst_ready4", rdy4, 0);
        step(8'h04, 1'b1, 1'b0, 1'b0, 1'b0);
        check("postrst_count4", cnt4, 1);
        check("postrst_data4",  rd4, 8'h04);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("postrst_drain4", cnt4, 0);

        // ---------------- wrap-around: 3 queued, 40 push/pop pairs ----------------
        for (int k = 0; k < 3; k++) step(8'(k), 1'b1, 1'b0, 1'b0, 1'b0);
        check("wrap_fill4", cnt4, 3);
        for (int k = 0; k < 40; k++) begin
            step(8'(k + 3), 1'b1, 1'b1, 1'b0, 1'b0);
            check($sformatf("wrap%0d_data4", k),  rd4, k + 1);
            check($sformatf("wrap%0d_count4", k), cnt4, 3);
            check($sformatf("wrap%0d_data2", k),  rd2, k + 1);
        end
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_tail0", rd4, 41);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_tail1", rd4, 42);
        step(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wrap_empty4", rdy4, 0);
        check("wrap_ovf4",   ovf4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
